// File: rtl/mem_ctrl.sv
`default_nettype none
// ==========================================================================
// mem_ctrl : byte-serial RAM/IO sequencer for I-cache line fills and LSB
//            loads/stores.                                    Revision 1.0
// ==========================================================================
module mem_ctrl (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         io_buffer_full,
  input  logic [7:0]   mem_din,
  output logic [7:0]   mem_dout,
  output logic [31:0]  mem_a,
  output logic         mem_wr,
  input  logic         ifetch_todo,
  input  logic [31:0]  ifetch_addr,
  output logic         ifetch_done,
  output logic [511:0] ifetch_res,
  input  logic         lsb_todo,
  input  logic         lsb_wr,
  input  logic [31:0]  lsb_addr,
  input  logic [1:0]   lsb_len,
  input  logic [31:0]  lsb_data,
  output logic         lsb_done,
  output logic [31:0]  lsb_res
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_IFETCH = 2'd1;
  localparam logic [1:0] ST_LOAD   = 2'd2;
  localparam logic [1:0] ST_STORE  = 2'd3;

  localparam logic [6:0] LINE_BYTES = 7'd64;

  logic [1:0]   state_q, state_d;
  logic [6:0]   cnt_q, cnt_d;
  logic [6:0]   len_q, len_d;
  logic [31:0]  base_q, base_d;
  logic [31:0]  data_q, data_d;
  logic [511:0] buf_q, buf_d;
  logic [7:0]   din_hold_q, din_hold_d;
  logic         held_q, held_d;
  logic [31:0]  mem_a_q, mem_a_d;
  logic         mem_wr_q, mem_wr_d;
  logic [7:0]   mem_dout_q, mem_dout_d;
  logic         ifetch_done_q, ifetch_done_d;
  logic [511:0] ifetch_res_q, ifetch_res_d;
  logic         lsb_done_q, lsb_done_d;
  logic [31:0]  lsb_res_q, lsb_res_d;

  logic [7:0]   din_eff;
  logic [511:0] buf_cap;
  logic [6:0]   lsb_n;
  logic         io_hold;

  assign mem_a       = mem_a_q;
  assign mem_wr      = mem_wr_q;
  assign mem_dout    = mem_dout_q;
  assign ifetch_done = ifetch_done_q;
  assign ifetch_res  = ifetch_res_q;
  assign lsb_done    = lsb_done_q;
  assign lsb_res     = lsb_res_q;

  always_comb begin
    // A stall leaves mem_a parked, so the byte already on mem_din is kept
    // aside and consumed on the first enabled edge after the stall.
    din_eff = held_q ? din_hold_q : mem_din;

    buf_cap = buf_q;
    if (cnt_q != 7'd0) begin
      buf_cap[{cnt_q[5:0] - 6'd1, 3'b000} +: 8] = din_eff;
    end

    case (lsb_len)
      2'd0:    lsb_n = 7'd1;
      2'd1:    lsb_n = 7'd2;
      default: lsb_n = 7'd4;
    endcase

    io_hold = (base_q[17:16] == 2'b11) && io_buffer_full;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    base_d        = base_q;
    data_d        = data_q;
    buf_d         = buf_q;
    din_hold_d    = din_hold_q;
    held_d        = held_q;
    mem_a_d       = mem_a_q;
    mem_wr_d      = mem_wr_q;
    mem_dout_d    = mem_dout_q;
    ifetch_done_d = ifetch_done_q;
    ifetch_res_d  = ifetch_res_q;
    lsb_done_d    = lsb_done_q;
    lsb_res_d     = lsb_res_q;

    if (!rdy_in) begin
      mem_wr_d = 1'b0;
      if (!held_q) begin
        din_hold_d = mem_din;
        held_d     = 1'b1;
      end
    end else begin
      held_d        = 1'b0;
      mem_wr_d      = 1'b0;
      ifetch_done_d = 1'b0;
      lsb_done_d    = 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (!ifetch_done_q && !lsb_done_q) begin
            if (lsb_todo) begin
              state_d = lsb_wr ? ST_STORE : ST_LOAD;
              base_d  = lsb_addr;
              len_d   = lsb_n;
              data_d  = lsb_data;
              cnt_d   = 7'd0;
              buf_d   = '0;
              mem_a_d = lsb_addr;
            end else if (ifetch_todo) begin
              state_d = ST_IFETCH;
              base_d  = ifetch_addr;
              len_d   = LINE_BYTES;
              cnt_d   = 7'd0;
              buf_d   = '0;
              mem_a_d = ifetch_addr;
            end
          end
        end

        ST_IFETCH, ST_LOAD: begin
          buf_d = buf_cap;
          if (cnt_q == len_q) begin
            state_d = ST_IDLE;
            cnt_d   = 7'd0;
            if (state_q == ST_IFETCH) begin
              ifetch_done_d = 1'b1;
              ifetch_res_d  = buf_cap;
            end else begin
              lsb_done_d = 1'b1;
              lsb_res_d  = buf_cap[31:0];
            end
          end else begin
            cnt_d = cnt_q + 7'd1;
            if ((cnt_q + 7'd1) < len_q) begin
              mem_a_d = base_q + {25'd0, cnt_q + 7'd1};
            end
          end
        end

        ST_STORE: begin
          if (cnt_q == len_q) begin
            state_d    = ST_IDLE;
            cnt_d      = 7'd0;
            lsb_done_d = 1'b1;
          end else if (!io_hold) begin
            mem_a_d    = base_q + {25'd0, cnt_q};
            mem_dout_d = data_q[{cnt_q[1:0], 3'b000} +: 8];
            mem_wr_d   = 1'b1;
            cnt_d      = cnt_q + 7'd1;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 7'd0;
      len_q         <= 7'd0;
      base_q        <= 32'd0;
      data_q        <= 32'd0;
      buf_q         <= '0;
      din_hold_q    <= 8'd0;
      held_q        <= 1'b0;
      mem_a_q       <= 32'd0;
      mem_wr_q      <= 1'b0;
      mem_dout_q    <= 8'd0;
      ifetch_done_q <= 1'b0;
      ifetch_res_q  <= '0;
      lsb_done_q    <= 1'b0;
      lsb_res_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      len_q         <= len_d;
      base_q        <= base_d;
      data_q        <= data_d;
      buf_q         <= buf_d;
      din_hold_q    <= din_hold_d;
      held_q        <= held_d;
      mem_a_q       <= mem_a_d;
      mem_wr_q      <= mem_wr_d;
      mem_dout_q    <= mem_dout_d;
      ifetch_done_q <= ifetch_done_d;
      ifetch_res_q  <= ifetch_res_d;
      lsb_done_q    <= lsb_done_d;
      lsb_res_q     <= lsb_res_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// tb_mem_ctrl : directed and randomized checks of mem_ctrl against a
//               byte-addressed memory model with spec-derived latencies.
module tb_mem_ctrl;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         rdy_in;
  logic         io_buffer_full;
  logic [7:0]   mem_din;
  logic [7:0]   mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr;
  logic         ifetch_todo;
  logic [31:0]  ifetch_addr;
  logic         ifetch_done;
  logic [511:0] ifetch_res;
  logic         lsb_todo;
  logic         lsb_wr;
  logic [31:0]  lsb_addr;
  logic [1:0]   lsb_len;
  logic [31:0]  lsb_data;
  logic         lsb_done;
  logic [31:0]  lsb_res;

  int checks;
  int errors;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .ifetch_todo(ifetch_todo), .ifetch_addr(ifetch_addr), .ifetch_done(ifetch_done),
    .ifetch_res(ifetch_res), .lsb_todo(lsb_todo), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr),
    .lsb_len(lsb_len), .lsb_data(lsb_data), .lsb_done(lsb_done), .lsb_res(lsb_res)
  );

  always #5 clk_in = ~clk_in;

  // Power-up RAM contents: byte k holds k, except 0x1001..0x1004 = 11 22 33 44.
  function automatic logic [7:0] init_byte(input logic [15:0] a);
    if (a >= 16'h1001 && a <= 16'h1004) return {5'd0, a[2:0]} * 8'h11;
    return a[7:0];
  endfunction

  // RAM device: 64 KiB decoded from mem_a[15:0], read data one cycle late.
  bit   [7:0]  ram_mem [65536];
  bit          ram_set [65536];
  logic [39:0] wlog [4096];
  int          wcnt;

  always @(posedge clk_in) begin
    mem_din <= ram_set[mem_a[15:0]] ? ram_mem[mem_a[15:0]] : init_byte(mem_a[15:0]);
    if (mem_wr) begin
      ram_mem[mem_a[15:0]] <= mem_dout;
      ram_set[mem_a[15:0]] <= 1'b1;
      wlog[wcnt[11:0]]     <= {mem_a, mem_dout};
      wcnt                 <= wcnt + 1;
    end
  end

  // Reference model state.
  logic [7:0]  ref_mem [int unsigned];
  logic [31:0] last_load;

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    int unsigned k;
    k = {16'd0, a[15:0]};
    if (ref_mem.exists(k)) return ref_mem[k];
    return init_byte(a[15:0]);
  endfunction

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in); #1;
  endtask

  task automatic lsb_op(input string tag, input bit wr, input logic [31:0] a, input logic [1:0] len,
                        input logic [31:0] d, input int rdy_at, input int rdy_n, input int full_n);
    int n, lat, exp_lat, w0, hold_bad;
    logic [31:0] res, exp_res;
    n = nbytes(len);
    exp_lat = n + 1 + rdy_n + ((wr && a[17:16] == 2'b11) ? full_n : 0);
    exp_res = 32'd0;
    if (wr) exp_res = last_load;
    else for (int i = 0; i < n; i++) exp_res |= 32'(ref_rd(a + 32'(i))) << (8 * i);
    w0 = wcnt; hold_bad = 0; lat = -1; res = 32'd0;
    lsb_wr = wr; lsb_addr = a; lsb_len = len; lsb_data = d; lsb_todo = 1'b1;
    io_buffer_full = (full_n > 0);
    for (int p = 0; p < 300 && lat < 0; p++) begin
      step();
      if (lsb_done) begin lat = p; res = lsb_res; end
      if (p >= 1 && p <= full_n && mem_wr) hold_bad++;
      if (full_n > 0 && p == full_n) io_buffer_full = 1'b0;
      if (rdy_n > 0 && p == rdy_at) rdy_in = 1'b0;
      if (rdy_n > 0 && p == rdy_at + rdy_n) rdy_in = 1'b1;
    end
    lsb_todo = 1'b0; io_buffer_full = 1'b0; rdy_in = 1'b1;
    chk({tag, " latency"}, 512'(lat), 512'(exp_lat));
    chk({tag, " lsb_res"}, 512'(res), 512'(exp_res));
    if (wr && a[17:16] == 2'b11 && full_n > 0) chk({tag, " io hold mem_wr"}, 512'(hold_bad), 512'(0));
    step();
    chk({tag, " done width"}, 512'(lsb_done), 512'(0));
    if (wr) begin
      chk({tag, " write count"}, 512'(wcnt - w0), 512'(n));
      for (int i = 0; i < n && i < wcnt - w0; i++)
        chk({tag, " write"}, 512'(wlog[(w0 + i) % 4096]), 512'({a + 32'(i), d[8*i +: 8]}));
      for (int i = 0; i < n; i++) ref_mem[{16'd0, a[15:0] + 16'(i)}] = d[8*i +: 8];
    end else begin
      last_load = exp_res;
    end
  endtask

  task automatic fetch_op(input string tag, input logic [31:0] a, input int rdy_at, input int rdy_n);
    int lat, bad_a;
    logic [511:0] res, exp_line;
    for (int i = 0; i < 64; i++) exp_line[8*i +: 8] = ref_rd(a + 32'(i));
    lat = -1; bad_a = 0; res = '0;
    ifetch_addr = a; ifetch_todo = 1'b1;
    for (int p = 0; p < 400 && lat < 0; p++) begin
      step();
      if (ifetch_done) begin lat = p; res = ifetch_res; end
      if (rdy_n == 0 && mem_a !== a + 32'((p < 63) ? p : 63)) bad_a++;
      if (rdy_n > 0 && p == rdy_at) rdy_in = 1'b0;
      if (rdy_n > 0 && p == rdy_at + rdy_n) rdy_in = 1'b1;
    end
    ifetch_todo = 1'b0; rdy_in = 1'b1;
    chk({tag, " latency"}, 512'(lat), 512'(65 + rdy_n));
    chk({tag, " line"}, res, exp_line);
    if (rdy_n == 0) chk({tag, " mem_a sequence"}, 512'(bad_a), 512'(0));
    step();
    chk({tag, " done width"}, 512'(ifetch_done), 512'(0));
  endtask

  initial begin
    int lat_l, lat_f, spurious;
    logic [31:0] res_l, ra, rd;
    logic [511:0] res_f, exp_line;
    logic [1:0] rl;
    bit rw;
    int fn, rn;

    checks = 0; errors = 0; last_load = 32'd0;
    rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
    ifetch_todo = 1'b0; ifetch_addr = 32'd0;
    lsb_todo = 1'b0; lsb_wr = 1'b0; lsb_addr = 32'd0; lsb_len = 2'd0; lsb_data = 32'd0;

    step(); step();
    chk("reset mem_a", 512'(mem_a), 512'(0));
    chk("reset mem_wr", 512'(mem_wr), 512'(0));
    chk("reset mem_dout", 512'(mem_dout), 512'(0));
    chk("reset ifetch_done", 512'(ifetch_done), 512'(0));
    chk("reset ifetch_res", ifetch_res, 512'(0));
    chk("reset lsb_done", 512'(lsb_done), 512'(0));
    chk("reset lsb_res", 512'(lsb_res), 512'(0));
    rst_in = 1'b0;
    step();

    fetch_op("fill 0x40", 32'h40, 0, 0);
    lsb_op("word load 0x1001", 1'b0, 32'h1001, 2'd2, 32'd0, 0, 0, 0);
    chk("word load value", 512'(last_load), 512'(32'h44332211));
    lsb_op("byte load 0x1001", 1'b0, 32'h1001, 2'd0, 32'd0, 0, 0, 0);
    chk("byte load value", 512'(last_load), 512'(32'h11));
    lsb_op("len3 load 0x1001", 1'b0, 32'h1001, 2'd3, 32'd0, 0, 0, 0);
    lsb_op("half store 0x200", 1'b1, 32'h200, 2'd1, 32'h0000BEEF, 0, 0, 0);
    lsb_op("half load 0x200", 1'b0, 32'h200, 2'd1, 32'd0, 0, 0, 0);
    chk("half readback", 512'(last_load), 512'(32'h0000BEEF));
    lsb_op("io store 0x30000", 1'b1, 32'h30000, 2'd0, 32'h000000A5, 0, 0, 5);
    lsb_op("io load 0x30004", 1'b0, 32'h30004, 2'd2, 32'd0, 0, 0, 3);
    lsb_op("wrap load", 1'b0, 32'hFFFFFFFF, 2'd2, 32'd0, 0, 0, 0);

    // Simultaneous requests: the load goes first, the fill one idle cycle later.
    for (int i = 0; i < 64; i++) exp_line[8*i +: 8] = ref_rd(32'h80 + 32'(i));
    ifetch_addr = 32'h80; ifetch_todo = 1'b1;
    lsb_wr = 1'b0; lsb_addr = 32'h1001; lsb_len = 2'd2; lsb_todo = 1'b1;
    lat_l = -1; lat_f = -1; res_l = 32'd0; res_f = '0;
    for (int p = 0; p < 400 && lat_f < 0; p++) begin
      step();
      if (lsb_done && lat_l < 0) begin lat_l = p; res_l = lsb_res; lsb_todo = 1'b0; end
      if (ifetch_done) begin lat_f = p; res_f = ifetch_res; end
    end
    ifetch_todo = 1'b0; lsb_todo = 1'b0;
    chk("priority load latency", 512'(lat_l), 512'(5));
    chk("priority load value", 512'(res_l), 512'(32'h44332211));
    chk("priority fill latency", 512'(lat_f), 512'(72));
    chk("priority fill line", res_f, exp_line);
    last_load = 32'h44332211;
    step();

    for (int k = 0; k < 24; k++) begin
      rw = 1'($urandom_range(0, 1));
      ra = 32'h2000 + 32'($urandom_range(0, 32'hFFF));
      if ($urandom_range(0, 3) == 0) ra = ra | 32'h30000;
      rl = 2'($urandom_range(0, 3));
      rd = $urandom;
      fn = $urandom_range(0, 3);
      rn = (fn > 0) ? 0 : $urandom_range(0, 2);
      lsb_op($sformatf("rand op %0d", k), rw, ra, rl, rd, 1, rn, fn);
    end
    fetch_op("rand fill", 32'h2000 + {20'd0, 6'($urandom_range(0, 63)), 6'd0}, 0, 0);

    fetch_op("stalled fill", 32'h40, 20, 3);
    lsb_op("stalled store", 1'b1, 32'h400, 2'd2, 32'hCAFEF00D, 2, 2, 0);
    lsb_op("stalled load", 1'b0, 32'h400, 2'd2, 32'd0, 2, 3, 0);

    // Asynchronous reset in the middle of a store.
    lsb_wr = 1'b1; lsb_addr = 32'h300; lsb_len = 2'd2; lsb_data = 32'h12345678; lsb_todo = 1'b1;
    step(); step(); step();
    #2 rst_in = 1'b1;
    #1;
    chk("mid reset mem_a", 512'(mem_a), 512'(0));
    chk("mid reset mem_wr", 512'(mem_wr), 512'(0));
    chk("mid reset mem_dout", 512'(mem_dout), 512'(0));
    chk("mid reset lsb_done", 512'(lsb_done), 512'(0));
    chk("mid reset lsb_res", 512'(lsb_res), 512'(0));
    chk("mid reset ifetch_res", ifetch_res, 512'(0));
    lsb_todo = 1'b0;
    step(); step();
    rst_in = 1'b0;
    spurious = 0;
    for (int p = 0; p < 10; p++) begin
      step();
      if (lsb_done || ifetch_done || mem_wr) spurious++;
    end
    chk("no activity after reset", 512'(spurious), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
